// File: rtl/key_provision_ctrl.sv
// Key provisioning controller: code-gated, time-limited single-key write window
// with consecutive-failure lockout that only reset can clear.
module key_provision_ctrl #(
    parameter logic [31:0] UNLOCK_CODE = 32'hA5C3_0F1E,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic [31:0] write_key,
    output logic        write_enable,
    output logic        unlocked,
    output logic        lockout,
    output logic [1:0]  fail_cnt,
    output logic        err
);

    localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0]  OP_UNLOCK = 2'b00;
    localparam logic [1:0]  OP_WRITE  = 2'b01;
    localparam logic [1:0]  OP_LOCK   = 2'b10;
    localparam logic [1:0]  FAIL_SAT  = 2'(MAX_FAIL);
    localparam logic [CW-1:0] WIN_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_UNLOCKED,
        S_WRITE,
        S_LOCKOUT
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     fail_q, fail_d;
    logic [CW-1:0]  win_q, win_d;
    logic [31:0]    key_q, key_d;
    logic           err_q, err_d;
    logic           accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOCKED;
            fail_q  <= '0;
            win_q   <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            win_q   <= win_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_LOCKED) || (state_q == S_UNLOCKED);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        win_d   = win_q;
        key_d   = key_q;
        err_d   = 1'b0;
        case (state_q)
            S_LOCKED: begin
                if (accept) begin
                    if (cmd_op == OP_UNLOCK && cmd_data == UNLOCK_CODE) begin
                        state_d = S_UNLOCKED;
                        fail_d  = '0;
                        win_d   = WIN_LOAD;
                    end else if (cmd_op == OP_UNLOCK) begin
                        err_d  = 1'b1;
                        fail_d = (fail_q == FAIL_SAT) ? fail_q : fail_q + 2'd1;
                        if (fail_d == FAIL_SAT) begin
                            state_d = S_LOCKOUT;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_UNLOCKED: begin
                if (win_q != '0) begin
                    win_d = win_q - 1'b1;
                end
                // An expired window closes regardless of what is offered;
                // only LOCK gets through that last cycle without an error.
                if (accept) begin
                    if (cmd_op == OP_WRITE) begin
                        if (win_q == '0) begin
                            err_d   = 1'b1;
                            state_d = S_LOCKED;
                        end else begin
                            key_d   = cmd_data;
                            state_d = S_WRITE;
                        end
                    end else if (cmd_op == OP_LOCK) begin
                        state_d = S_LOCKED;
                    end else begin
                        err_d = 1'b1;
                        if (win_q == '0) begin
                            state_d = S_LOCKED;
                        end
                    end
                end else if (win_q == '0) begin
                    state_d = S_LOCKED;
                end
            end
            S_WRITE: begin
                key_d   = '0;
                state_d = S_LOCKED;
            end
            S_LOCKOUT: begin
                state_d = S_LOCKOUT;
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    always_comb begin
        write_enable = (state_q == S_WRITE) && !rst;
        write_key    = write_enable ? key_q : '0;
        unlocked     = (state_q == S_UNLOCKED);
        lockout      = (state_q == S_LOCKOUT);
        fail_cnt     = fail_q;
        err          = err_q;
    end

endmodule

// File: tb/tb_key_provision_ctrl.sv
// Scoreboard bench for key_provision_ctrl: directed scenarios plus random
// commands, predicted by a window/fail-count model and checked by a monitor.
module tb_key_provision_ctrl;

    localparam logic [31:0] CODE = 32'hA5C3_0F1E;
    localparam int          MAXF = 3;
    localparam int          TMO  = 16;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [31:0] write_key;
    logic        write_enable;
    logic        unlocked;
    logic        lockout;
    logic [1:0]  fail_cnt;
    logic        err;

    key_provision_ctrl #(
        .UNLOCK_CODE (CODE),
        .MAX_FAIL    (MAXF),
        .TIMEOUT     (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .write_key    (write_key),
        .write_enable (write_enable),
        .unlocked     (unlocked),
        .lockout      (lockout),
        .fail_cnt     (fail_cnt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  st;   // {ready, unlocked, lockout, fail[1:0], err, we}
        logic [31:0] key;
    } exp_t;

    exp_t        sq[$];
    logic [31:0] wq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc_n  = 0;

    // Reference model: window described as "cycles of window remaining".
    bit          m_open, m_dead, m_pend;
    int          m_left, m_fails;
    logic [31:0] m_key;

    task automatic model_step(input logic r, input logic v, input logic [1:0] op,
                              input logic [31:0] d);
        bit   e;
        bit   last;
        exp_t x;
        e = 0;
        if (r) begin
            m_open = 0; m_dead = 0; m_pend = 0; m_left = 0; m_fails = 0; m_key = '0;
        end else if (m_pend) begin
            m_pend = 0;
            m_key  = '0;
        end else if (m_dead) begin
            // commands ignored
        end else if (m_open) begin
            last   = (m_left == 1);
            m_left = m_left - 1;
            if (v && op == 2'd1) begin
                m_open = 0;
                if (last) e = 1;
                else begin m_pend = 1; m_key = d; end
            end else if (v && op == 2'd2) begin
                m_open = 0;
            end else if (v) begin
                e = 1;
                if (last) m_open = 0;
            end else if (last) begin
                m_open = 0;
            end
        end else if (v) begin
            if (op == 2'd0 && d == CODE) begin
                m_open = 1; m_left = TMO; m_fails = 0;
            end else if (op == 2'd0) begin
                e = 1;
                if (m_fails < MAXF) m_fails++;
                if (m_fails == MAXF) m_dead = 1;
            end else begin
                e = 1;
            end
        end
        x.st  = {!(m_dead || m_pend), m_open, m_dead, 2'(m_fails), e, m_pend};
        x.key = m_pend ? m_key : 32'h0;
        sq.push_back(x);
        if (m_pend) wq.push_back(m_key);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [1:0] op,
                       input logic [31:0] d);
        rst = r; cmd_valid = v; cmd_op = op; cmd_data = d;
        model_step(r, v, op, d);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    // Monitor: compares after every edge, and checks each observed strobe.
    initial begin
        exp_t        e;
        logic [31:0] k;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                checks++;
                if ({cmd_ready, unlocked, lockout, fail_cnt, err, write_enable} !== e.st) begin
                    errors++;
                    $display("FAIL status cyc=%0d got=%b exp=%b (rdy,unl,lko,fail2,err,we)",
                             cyc_n, {cmd_ready, unlocked, lockout, fail_cnt, err, write_enable}, e.st);
                end
                checks++;
                if (write_key !== e.key) begin
                    errors++;
                    $display("FAIL write_key cyc=%0d got=%h exp=%h", cyc_n, write_key, e.key);
                end
            end
            if (write_enable === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d got key=%h exp no strobe", cyc_n, write_key);
                end else begin
                    k = wq.pop_front();
                    if (write_key !== k) begin
                        errors++;
                        $display("FAIL write_data cyc=%0d got=%h exp=%h", cyc_n, write_key, k);
                    end
                end
            end
        end
    end

    initial begin
        logic        r, v;
        logic [1:0]  op;
        logic [31:0] d;
        cyc(1'b1, 1'b0, 2'd0, 32'h0);
        cyc(1'b1, 1'b1, 2'd0, CODE);
        // Unlock then key write
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF);
        idle(2);
        // Three bad unlocks -> lockout, correct code ignored
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd0, 32'h0000_0001);
        cyc(1'b0, 1'b1, 2'd0, CODE);
        idle(2);
        cyc(1'b1, 1'b0, 2'd0, 32'h0);
        // Window expiry then write
        cyc(1'b0, 1'b1, 2'd0, CODE);
        idle(16);
        cyc(1'b0, 1'b1, 2'd1, 32'hCAFE_0001);
        idle(1);
        // Write while locked
        cyc(1'b0, 1'b1, 2'd1, 32'h1234_5678);
        idle(1);
        // Unlock then lock
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b0, 1'b1, 2'd2, 32'h0);
        idle(1);
        // bad, bad, good, lock, bad -> fail 1,2,0,0,1
        cyc(1'b0, 1'b1, 2'd0, 32'h0BAD_0BAD);
        cyc(1'b0, 1'b1, 2'd0, 32'h0BAD_0BAD);
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b0, 1'b1, 2'd2, 32'h0);
        cyc(1'b0, 1'b1, 2'd0, 32'h0BAD_0BAD);
        idle(1);
        cyc(1'b1, 1'b0, 2'd0, 32'h0);
        // Last window cycle: write rejected, lock clean
        cyc(1'b0, 1'b1, 2'd0, CODE);
        idle(15);
        cyc(1'b0, 1'b1, 2'd1, 32'h5555_AAAA);
        cyc(1'b0, 1'b1, 2'd0, CODE);
        idle(15);
        cyc(1'b0, 1'b1, 2'd2, 32'h0);
        // Unlock/reserved inside the window: err, window kept
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b0, 1'b1, 2'd3, 32'h0);
        cyc(1'b0, 1'b1, 2'd1, 32'h0F0F_F0F0);
        idle(2);
        // Reset coinciding with the strobe edge, and reset during the strobe
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b1, 1'b1, 2'd1, 32'h7777_7777);
        idle(2);
        cyc(1'b0, 1'b1, 2'd0, CODE);
        cyc(1'b0, 1'b1, 2'd1, 32'h8888_8888);
        cyc(1'b1, 1'b0, 2'd0, 32'h0);
        idle(2);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 7);
            op = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 1) == 1) ? CODE : $urandom();
            cyc(r, v, op, d);
        end
        idle(3);
        checks++;
        if (wq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain got wq=%0d sq=%0d exp 0 0", wq.size(), sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
